seven_segment_scanner: RTL
==========================

# seven_segment_scanner

Time-multiplexed driver for the four-digit, common-anode seven-segment display, sitting directly downstream of the stopwatch counter. It consumes four 4-bit hex digits and produces the `anode_bits`, `seven_segments_LED_output` and `decimal_point` board pins.
- Digits are snapshotted once per frame so the display never tears.
- Each digit slot begins with an anti-ghosting blank interval.
- Supports decimal-point placement and leading-zero suppression.

## Interface
Parameters:
- `SCAN_DIV`, default 100_000: clock cycles per digit slot (1 ms at 100 MHz, 250 Hz frame). Must be ≥ 4.
- `BLANK_CYCLES`, default 1_000: cycles at the start of each slot with all anodes off. Requires 1 ≤ `BLANK_CYCLES` < `SCAN_DIV`.

Ports:
- `clk` — in, 1: 100 MHz system clock.
- `negated_reset` — in, 1: asynchronous, active-low reset.
- `display_on` — in, 1: when 0, all anodes are forced off; scanning continues.
- `third_hex_digit`, `second_hex_digit`, `first_hex_digit`, `zero_hex_digit` — in, 4 each: digits 3 (leftmost) to 0 (rightmost).
- `dp_enable` — in, 1: enables the decimal point.
- `dp_position` — in, 2: index of the digit that carries the decimal point.
- `blank_leading_zeros` — in, 1: enables leading-zero suppression.
- `anode_bits` — out, 4: active-low digit enables; bit k drives digit k.
- `seven_segments_LED_output` — out, 8: active-low segments. Bits [6:0] = g,f,e,d,c,b,a; bit 7 is constant 1.
- `decimal_point` — out, 1: active-low DP.
- `LED_binary_coded_decimal` — out, 4: the digit currently selected (debug visibility).
- `frame_tick` — out, 1: one-cycle pulse on the last cycle of slot 3.

## Operation
- Slot counter `cnt` runs 0..`SCAN_DIV`-1. At wrap, slot index `slot` (2 bits) increments 3→0.
- Phase FSM, two states:
  - BLANK while `cnt` < `BLANK_CYCLES`: anodes = 4'hF, segments = 8'hFF, DP = 1.
  - DRIVE for the rest of the slot: anode = ~(1<<slot), segments = decode(snapshot[slot]).
  - Transitions: BLANK→DRIVE at `cnt` == `BLANK_CYCLES`-1. DRIVE→BLANK at `cnt` == `SCAN_DIV`-1.
- Snapshot: all four digits, `dp_enable`, `dp_position` and `blank_leading_zeros` are captured together on the cycle `slot` wraps 3→0. Input changes mid-frame are invisible until the next frame.
- Decode (hex, 8-bit output):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Leading-zero suppression, evaluated on the snapshot:
  - Digit k (k = 3,2,1) is blanked (segments FF, anode still asserted) if its value is 0, every digit left of it is blanked, and, when the snapshotted `dp_enable` is set, k > `dp_position`.
  - Digit 0 is never blanked.
- DP: `decimal_point` = 0 only in DRIVE, with snapshot `dp_enable`=1 and `slot`==`dp_position`. The DP is shown even on a blanked digit.
- `display_on`=0 is applied combinationally before the output register: anodes = F, segments = FF, DP = 1. Counters, slot and snapshot continue.
- `LED_binary_coded_decimal` = snapshot[slot], registered.

## Timing
- All outputs are registered and lag the internal `cnt`/`slot` state by one cycle.
- Reset (async assert, sync release internally by flop):
  - `cnt`=0, `slot`=0, FSM=BLANK, snapshot=0.
  - Outputs: `anode_bits`=4'hF, `seven_segments_LED_output`=8'hFF, `decimal_point`=1, `LED_binary_coded_decimal`=0, `frame_tick`=0.
- After reset, the first DRIVE output appears `BLANK_CYCLES`+1 cycles after release. That first frame shows the reset snapshot (digit 0 = "0", digits 3..1 = "0"; no blanking because `blank_leading_zeros` is snapshotted as 0).
- Frame period = 4·`SCAN_DIV`. `frame_tick` has exactly one high cycle per frame.
- Reset mid-DRIVE: all outputs go to their reset values immediately, without waiting for a clock edge.
- No two anodes are ever low in the same cycle. At least `BLANK_CYCLES` all-off cycles separate any two driven digits.

## Structure
- Shared package `seven_seg_pkg`:
  - Phase enum `scan_phase_t` {BLANK, DRIVE}.
  - Constants `SEG_BLANK`=8'hFF and `ANODE_OFF`=4'hF.
  - Function `hex_to_segments` (4-bit → 8-bit, per the table in Operation).
- One natural sub-module, `digit_blanker`: combinational leading-zero and DP mask computed from the snapshot. The top holds the counters, FSM, snapshot and output registers.

## Test plan
All scenarios use `SCAN_DIV`=8, `BLANK_CYCLES`=2.
- Reset release, digits 1,2,3,4 applied: anodes stay F for 3 cycles. In frame 2, the slots show segments 99 (anode E), B0 (D), A4 (B), F9 (7), each held 6 cycles with 2 all-off cycles between.
- Digits 0,0,0,5, `blank_leading_zeros`=1, `dp_enable`=0: slots 3..1 show FF with anode asserted; slot 0 shows 92.
- Same digits, `dp_enable`=1, `dp_position`=2: digit 3 blanked; digit 2 shows C0 with `decimal_point`=0 only during slot 2 DRIVE; digit 1 shows C0.
- Digits change from 1111 to 2222 during slot 1: rest of the frame still shows F9; next frame shows A4 everywhere.
- `display_on` low for one frame: anodes = F throughout. `frame_tick` still pulses once every 32 cycles.
- `negated_reset` pulsed low mid-DRIVE of slot 2: outputs go to F / FF / 1 asynchronously. On release, the sequence restarts at slot 0 BLANK.

Source files
------------

// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_pkg
//  Description : Shared types, constants and the hex-to-segment decoder for
//                the four-digit seven-segment scanner.
//                - scan_phase_t    : per-slot phase (BLANK / DRIVE)
//                - snapshot_t      : per-frame capture of digits + controls
//                - SEG_BLANK       : all segments off (active-low)
//                - ANODE_OFF       : all anodes off (active-low)
//                - hex_to_segments : 4-bit hex -> 8-bit active-low pattern
//  Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_phase_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  // digits[3] is the leftmost digit, digits[0] the rightmost.
  typedef struct packed {
    logic [3:0][3:0] digits;
    logic            dp_enable;
    logic [1:0]      dp_position;
    logic            blank_leading_zeros;
  } snapshot_t;

  // Bit 7 is unused on the board and always reads 1; bits [6:0] = g..a.
  function automatic logic [7:0] hex_to_segments(input logic [3:0] hex);
    logic [7:0] seg;
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seven_segment_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : seven_segment_scanner_if
//  Description : Digit/control inputs and board-pin outputs of the scanner.
//                master : upstream source of digits, observer of the pins
//                slave  : the scanner itself
//                Inputs : display_on, third/second/first/zero_hex_digit[3:0],
//                         dp_enable, dp_position[1:0], blank_leading_zeros
//                Outputs: anode_bits[3:0], seven_segments_LED_output[7:0],
//                         decimal_point, LED_binary_coded_decimal[3:0],
//                         frame_tick
//  Revision    : 1.0 - initial release
// ============================================================================
interface seven_segment_scanner_if;

  logic       display_on;
  logic [3:0] third_hex_digit;
  logic [3:0] second_hex_digit;
  logic [3:0] first_hex_digit;
  logic [3:0] zero_hex_digit;
  logic       dp_enable;
  logic [1:0] dp_position;
  logic       blank_leading_zeros;

  logic [3:0] anode_bits;
  logic [7:0] seven_segments_LED_output;
  logic       decimal_point;
  logic [3:0] LED_binary_coded_decimal;
  logic       frame_tick;

  modport master (
    output display_on, third_hex_digit, second_hex_digit, first_hex_digit,
           zero_hex_digit, dp_enable, dp_position, blank_leading_zeros,
    input  anode_bits, seven_segments_LED_output, decimal_point,
           LED_binary_coded_decimal, frame_tick
  );

  modport slave (
    input  display_on, third_hex_digit, second_hex_digit, first_hex_digit,
           zero_hex_digit, dp_enable, dp_position, blank_leading_zeros,
    output anode_bits, seven_segments_LED_output, decimal_point,
           LED_binary_coded_decimal, frame_tick
  );

endinterface
`default_nettype wire

// File: rtl/digit_blanker.sv
`default_nettype none
// ============================================================================
//  Module      : digit_blanker
//  Description : Combinational leading-zero and decimal-point masks computed
//                from the per-frame snapshot.
//                snap       : in  - frozen digits and display controls
//                blank_mask : out - bit k set => digit k shows no segments
//                dp_mask    : out - bit k set => digit k carries the DP
//  Revision    : 1.0 - initial release
// ============================================================================
module digit_blanker
  import seven_seg_pkg::*;
(
  input  snapshot_t  snap,
  output logic [3:0] blank_mask,
  output logic [3:0] dp_mask
);

  logic blank3;
  logic blank2;
  logic blank1;

  // A digit is a leading zero only if every digit to its left is one too.
  // Suppression stops at the DP digit so "0.5" keeps its integer zero.
  always_comb begin
    blank3 = snap.blank_leading_zeros && (snap.digits[3] == 4'h0) &&
             (!snap.dp_enable || (snap.dp_position < 2'd3));
    blank2 = blank3 && (snap.digits[2] == 4'h0) &&
             (!snap.dp_enable || (snap.dp_position < 2'd2));
    blank1 = blank2 && (snap.digits[1] == 4'h0) &&
             (!snap.dp_enable || (snap.dp_position < 2'd1));
    // Digit 0 always shows something, even for an all-zero value.
    blank_mask = {blank3, blank2, blank1, 1'b0};
    dp_mask    = snap.dp_enable ? (4'b0001 << snap.dp_position) : 4'b0000;
  end

endmodule
`default_nettype wire

// File: rtl/seven_segment_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : seven_segment_scanner
//  Description : Time-multiplexed driver for a four-digit common-anode
//                seven-segment display. Digits are frozen once per frame,
//                every slot opens with an all-off anti-ghosting interval.
//                clk           : in  - system clock
//                negated_reset : in  - asynchronous active-low reset
//                bus           : slave side of seven_segment_scanner_if
//                Parameters    : SCAN_DIV (cycles per slot, >= 4)
//                                BLANK_CYCLES (1 <= BLANK_CYCLES < SCAN_DIV)
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int SCAN_DIV     = 100_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic                    clk,
  input  logic                    negated_reset,
  seven_segment_scanner_if.slave  bus
);

  localparam int               CNT_W      = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  // Scan state
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       slot_q, slot_d;
  scan_phase_t      phase_q, phase_d;
  snapshot_t        snap_q, snap_d;

  // Registered board pins
  logic [3:0] anode_q, anode_d;
  logic [7:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic [3:0] bcd_q, bcd_d;
  logic       frame_tick_q, frame_tick_d;

  logic       cnt_last;
  logic       frame_wrap;
  logic       show;
  logic [3:0] blank_mask;
  logic [3:0] dp_mask;

  digit_blanker u_digit_blanker (
    .snap       (snap_q),
    .blank_mask (blank_mask),
    .dp_mask    (dp_mask)
  );

  always_comb begin
    cnt_last   = (cnt_q == CNT_LAST);
    frame_wrap = cnt_last && (slot_q == 2'd3);

    cnt_d  = cnt_last ? '0 : cnt_q + CNT_W'(1);
    slot_d = cnt_last ? slot_q + 2'd1 : slot_q;

    phase_d = phase_q;
    case (phase_q)
      BLANK:   if (cnt_q == BLANK_LAST) phase_d = DRIVE;
      DRIVE:   if (cnt_last)            phase_d = BLANK;
      default: phase_d = BLANK;
    endcase

    // Capture coincides with slot 3 -> 0 so a whole frame shows one value.
    snap_d = snap_q;
    if (frame_wrap) begin
      snap_d.digits[3]           = bus.third_hex_digit;
      snap_d.digits[2]           = bus.second_hex_digit;
      snap_d.digits[1]           = bus.first_hex_digit;
      snap_d.digits[0]           = bus.zero_hex_digit;
      snap_d.dp_enable           = bus.dp_enable;
      snap_d.dp_position         = bus.dp_position;
      snap_d.blank_leading_zeros = bus.blank_leading_zeros;
    end

    // display_on gates only the pins; scanning and capture keep running.
    show = (phase_q == DRIVE) && bus.display_on;

    anode_d = ANODE_OFF;
    seg_d   = SEG_BLANK;
    dp_d    = 1'b1;
    if (show) begin
      anode_d = ~(4'b0001 << slot_q);
      seg_d   = blank_mask[slot_q] ? SEG_BLANK
                                   : hex_to_segments(snap_q.digits[slot_q]);
      // The DP survives leading-zero blanking of its own digit.
      dp_d    = ~dp_mask[slot_q];
    end

    bcd_d        = snap_q.digits[slot_q];
    frame_tick_d = frame_wrap;
  end

  always_ff @(posedge clk or negedge negated_reset) begin
    if (!negated_reset) begin
      cnt_q        <= '0;
      slot_q       <= 2'd0;
      phase_q      <= BLANK;
      snap_q       <= '0;
      anode_q      <= ANODE_OFF;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      bcd_q        <= 4'h0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      phase_q      <= phase_d;
      snap_q       <= snap_d;
      anode_q      <= anode_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      bcd_q        <= bcd_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.anode_bits                = anode_q;
  assign bus.seven_segments_LED_output = seg_q;
  assign bus.decimal_point             = dp_q;
  assign bus.LED_binary_coded_decimal  = bcd_q;
  assign bus.frame_tick                = frame_tick_q;

endmodule
`default_nettype wire
